seg7_mux_driver: RTL and testbench

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex7seg.sv | 11 +
 rtl/seg7_mux_driver.sv | 124 ++++++++++++
 tb/tb_seg7_mux_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: hex segment table, blank pattern and
// parameter bounds.
package seg7_pkg;

    localparam int unsigned N_DIG_MIN    = 1;
    localparam int unsigned N_DIG_MAX    = 8;
    localparam int unsigned PRESCALE_MIN = 2;
    localparam int unsigned PRESCALE_MAX = 1 << 20;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low gfedcba patterns, entry 15 (F) first so that SEG_TABLE[n] is nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1011000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment (gfedcba) decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver with shadow register and anti-ghost blanking.
// Optional leading-zero suppression is compiled in with SEG7_LEADING_ZERO_BLANK_EN.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG    = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] A,
    input  logic [N_DIG-1:0]   DP,
    input  logic               load,
    output logic [6:0]         L,
    output logic               H,
    output logic [N_DIG-1:0]   Dig
);

    localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    if (N_DIG < N_DIG_MIN || N_DIG > N_DIG_MAX) begin : g_bad_n_dig
        $error("seg7_mux_driver: N_DIG must be in 1..8");
    end
    if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
        $error("seg7_mux_driver: PRESCALE must be in 2..2^20");
    end

    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [4*N_DIG-1:0] r_a;
    logic [N_DIG-1:0]   r_dp;
    logic [6:0]         r_l;
    logic               r_h;
    logic [N_DIG-1:0]   r_dig;

    logic               w_tick;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic [N_DIG-1:0]   w_dig;
    logic [6:0]         w_seg;
    logic [6:0]         w_l;

    assign w_tick = (r_cnt == CNT_W'(PRESCALE - 1));

    always_comb begin
        w_nib = 4'h0;
        w_dp  = 1'b0;
        w_dig = '1;
        for (int k = 0; k < N_DIG; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib    = r_a[4*k +: 4];
                w_dp     = r_dp[k];
                w_dig[k] = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_zero_run;
    logic w_blank_lz;

    // Walk down from the top digit; a digit is suppressed while everything from it upward is 0.
    always_comb begin
        w_zero_run = 1'b1;
        w_blank_lz = 1'b0;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_a[4*k +: 4] == 4'h0);
            if (r_idx == IDX_W'(k)) begin
                w_blank_lz = w_zero_run;
            end
        end
    end

    assign w_l = w_blank_lz ? SEG_OFF : w_seg;
`else
    assign w_l = w_seg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_a   <= '0;
            r_dp  <= '0;
            r_l   <= SEG_OFF;
            r_h   <= 1'b1;
            r_dig <= '1;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(N_DIG - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (load) begin
                r_a  <= A;
                r_dp <= DP;
            end

            // The cycle after tick is blanked so the old digit never shows under the new enable.
            if (w_tick) begin
                r_l   <= SEG_OFF;
                r_h   <= 1'b1;
                r_dig <= '1;
            end else begin
                r_l   <= w_l;
                r_h   <= ~w_dp;
                r_dig <= w_dig;
            end
        end
    end

    assign L   = r_l;
    assign H   = r_h;
    assign Dig = r_dig;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed self-checking bench for seg7_mux_driver at N_DIG=4, PRESCALE=4.
// Expectations follow SEG7_LEADING_ZERO_BLANK_EN when the macro is defined.
module tb_seg7_mux_driver;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [3:0]  DP;
    logic        load;
    logic [6:0]  L;
    logic        H;
    logic [3:0]  Dig;

    logic [15:0] sh_a;
    logic [3:0]  sh_dp;
    int          n_checks;
    int          n_pass;

    seg7_mux_driver #(
        .N_DIG    (4),
        .PRESCALE (4)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .DP   (DP),
        .load (load),
        .L    (L),
        .H    (H),
        .Dig  (Dig)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int k);
        logic [3:0] nib;
        logic [6:0] seg;
        nib = sh[4*k +: 4];
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1011000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k > 0 && (sh >> (4 * k)) == 16'h0000) begin
            seg = 7'b1111111;
        end
`endif
        return seg;
    endfunction

    // One slot of digit k: three driven cycles then the blank cycle produced by tick.
    // load_at selects the step (0..3) whose edge captures new_a/new_dp, or -1 for none.
    task automatic run_slot(input int k, input int load_at, input logic [15:0] new_a,
                            input logic [3:0] new_dp, input string tag);
        for (int s = 0; s < 4; s++) begin
            logic [6:0] el;
            logic       eh;
            logic [3:0] ed;
            if (s < 3) begin
                el    = exp_seg(sh_a, k);
                eh    = ~sh_dp[k];
                ed    = 4'hF;
                ed[k] = 1'b0;
            end else begin
                el = 7'b1111111;
                eh = 1'b1;
                ed = 4'hF;
            end
            if (s == load_at) begin
                load = 1'b1;
                A    = new_a;
                DP   = new_dp;
            end
            step();
            load = 1'b0;
            check_eq($sformatf("%s d%0d s%0d Dig", tag, k, s), 32'(Dig), 32'(ed));
            check_eq($sformatf("%s d%0d s%0d L", tag, k, s), 32'(L), 32'(el));
            check_eq($sformatf("%s d%0d s%0d H", tag, k, s), 32'(H), 32'(eh));
            if (s == load_at) begin
                sh_a  = new_a;
                sh_dp = new_dp;
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        A        = 16'h0000;
        DP       = 4'b0000;
        load     = 1'b0;
        sh_a     = 16'h0000;
        sh_dp    = 4'b0000;
        n_checks = 0;
        n_pass   = 0;

        step();
        step();
        check_eq("reset L", 32'(L), 32'h7F);
        check_eq("reset H", 32'(H), 32'h1);
        check_eq("reset Dig", 32'(Dig), 32'hF);

        // All-zero scan straight out of reset; BEEF loaded on the final tick edge.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_slot(k, (k == 3) ? 3 : -1, 16'hBEEF, 4'b0100, "zero");
        end

        // Inputs move without load: two full scans must still show BEEF.
        A  = 16'h1234;
        DP = 4'b1111;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) begin
                run_slot(k, -1, 16'h0000, 4'b0000, "hold");
            end
        end

        // Mid-slot load on digit 1: one more old cycle, then the new nibble.
        run_slot(0, -1, 16'h0000, 4'b0000, "mid");
        run_slot(1, 1, 16'h1234, 4'b0001, "mid");
        run_slot(2, -1, 16'h0000, 4'b0000, "mid");
        run_slot(3, -1, 16'h0000, 4'b0000, "mid");

        // Reset mid-slot on digit 2 while load is also requested.
        run_slot(0, -1, 16'h0000, 4'b0000, "prerst");
        run_slot(1, -1, 16'h0000, 4'b0000, "prerst");
        step();
        check_eq("prerst d2 Dig", 32'(Dig), 32'hB);
        check_eq("prerst d2 L", 32'(L), 32'(7'b0100100));
        rst  = 1'b1;
        load = 1'b1;
        A    = 16'hFFFF;
        DP   = 4'b1111;
        step();
        rst  = 1'b0;
        load = 1'b0;
        check_eq("midrst L", 32'(L), 32'h7F);
        check_eq("midrst H", 32'(H), 32'h1);
        check_eq("midrst Dig", 32'(Dig), 32'hF);
        sh_a  = 16'h0000;
        sh_dp = 4'b0000;
        run_slot(0, -1, 16'h0000, 4'b0000, "postrst");
        run_slot(1, -1, 16'h0000, 4'b0000, "postrst");
        run_slot(2, -1, 16'h0000, 4'b0000, "postrst");
        run_slot(3, 3, 16'h0050, 4'b0000, "postrst");

        // Leading-zero patterns.
        for (int k = 0; k < 4; k++) begin
            run_slot(k, (k == 3) ? 3 : -1, 16'h0000, 4'b0000, "lz0050");
        end
        for (int k = 0; k < 4; k++) begin
            run_slot(k, -1, 16'h0000, 4'b0000, "lz0000");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
